// File: rtl/keypad4x4_scanner_pkg.sv
// ---------------------------------------------------------------------------
// keypad4x4_scanner_pkg
//   Shared definitions for the 4x4 keypad scanner: FSM state encoding, key
//   code constants, the row reset pattern and small helpers for the key map,
//   column decoding and row drive.
//   No ports (package).
// ---------------------------------------------------------------------------
package keypad4x4_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } scan_state_t;

  localparam logic [3:0] KEY_STAR          = 4'hE;
  localparam logic [3:0] KEY_HASH          = 4'hF;
  localparam logic [3:0] KEY_MAX_DIGIT     = 4'h9;
  localparam logic [1:0] ROW_RESET_IDX     = 2'd0;
  localparam logic [3:0] ROW_RESET_PATTERN = 4'b1110;
  localparam logic [3:0] COL_IDLE          = 4'b1111;

  // Keypad legend: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // True when exactly one column is pulled low; zero or several lows is "no key".
  function automatic logic single_zero(input logic [3:0] cols);
    return (cols == 4'b1110) || (cols == 4'b1101) ||
           (cols == 4'b1011) || (cols == 4'b0111);
  endfunction

  // Index of the low column; only meaningful when single_zero() holds.
  function automatic logic [1:0] zero_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Active-low one-cold row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] drive;
    case (idx)
      2'd1:    drive = 4'b1101;
      2'd2:    drive = 4'b1011;
      2'd3:    drive = 4'b0111;
      default: drive = ROW_RESET_PATTERN;
    endcase
    return drive;
  endfunction

endpackage

// File: rtl/keypad4x4_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad4x4_scanner_if
//   Key event bundle produced by the keypad scanner.
//   key_code   last accepted key code, held until next accept
//   key_valid  one-cycle strobe on key accept
//   key_down   high from accept until the release is debounced
//   bcd_entry  entered digits, [3:0] most recent
//   master: scanner side (drives), slave: consumer side (reads).
// ---------------------------------------------------------------------------
interface keypad4x4_scanner_if #(
  parameter int BCD_DIGITS = 3
);
  logic [3:0]              key_code;
  logic                    key_valid;
  logic                    key_down;
  logic [4*BCD_DIGITS-1:0] bcd_entry;

  modport master (output key_code, key_valid, key_down, bcd_entry);
  modport slave  (input  key_code, key_valid, key_down, bcd_entry);
endinterface

// File: rtl/keypad4x4_scanner_slot_tick_gen.sv
// ---------------------------------------------------------------------------
// slot_tick_gen
//   Free-running slot timer: tick is a one-cycle pulse every SCAN_TICKS+1
//   clocks, the first one SCAN_TICKS+1 clocks after reset.
//   clk_50MHz     in  system clock
//   reset_button  in  synchronous active-high reset
//   tick          out one-cycle pulse at the end of each slot
// ---------------------------------------------------------------------------
module slot_tick_gen #(
  parameter int SCAN_TICKS = 49_999
) (
  input  logic clk_50MHz,
  input  logic reset_button,
  output logic tick
);

  localparam int CW = (SCAN_TICKS < 1) ? 1 : $clog2(SCAN_TICKS + 1);

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == CW'(SCAN_TICKS));

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/keypad4x4_scanner.sv
// ---------------------------------------------------------------------------
// keypad4x4_scanner
//   Scans a 4x4 matrix keypad (rows driven active-low, columns read back),
//   debounces press and release over DB_SLOTS row slots, emits one key code
//   strobe per press and folds digit keys into a BCD entry register.
//   clk_50MHz     in  system clock
//   reset_button  in  synchronous active-high reset
//   col_in[3:0]   in  keypad columns, active-low, asynchronous
//   row_out[3:0]  out row drive, active-low, exactly one bit low
//   kp            master side of keypad4x4_scanner_if (key_code, key_valid,
//                 key_down, bcd_entry)
// ---------------------------------------------------------------------------
module keypad4x4_scanner
  import keypad4x4_scanner_pkg::*;
#(
  parameter int SCAN_TICKS = 49_999,
  parameter int DB_SLOTS   = 20,
  parameter int BCD_DIGITS = 3
) (
  input  logic                       clk_50MHz,
  input  logic                       reset_button,
  input  logic [3:0]                 col_in,
  output logic [3:0]                 row_out,
  keypad4x4_scanner_if.master        kp
);

  localparam int DBW = $clog2(DB_SLOTS + 1);
  localparam int BW  = 4 * BCD_DIGITS;

  logic            tick;
  logic [3:0]      col_meta_reg;
  logic [3:0]      col_sync_reg;

  scan_state_t     state_reg,     state_next;
  logic [1:0]      row_idx_reg,   row_idx_next;
  logic [1:0]      col_idx_reg,   col_idx_next;
  logic [3:0]      col_pat_reg,   col_pat_next;
  logic [DBW-1:0]  db_cnt_reg,    db_cnt_next;
  logic [3:0]      key_code_reg,  key_code_next;
  logic            key_valid_reg, key_valid_next;
  logic            key_down_reg,  key_down_next;
  logic [BW-1:0]   bcd_reg;
  logic [BW-1:0]   bcd_shifted;
  logic            db_done;

  slot_tick_gen #(
    .SCAN_TICKS (SCAN_TICKS)
  ) u_tick (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .tick         (tick)
  );

  // Columns are asynchronous to clk; two flops before any decision.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      col_meta_reg <= COL_IDLE;
      col_sync_reg <= COL_IDLE;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  // The detecting sample counts as 1, so this tick's match is the DB_SLOTS-th.
  assign db_done = (db_cnt_reg >= DBW'(DB_SLOTS - 1));

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      state_reg     <= ST_SCAN;
      row_idx_reg   <= ROW_RESET_IDX;
      col_idx_reg   <= 2'd0;
      col_pat_reg   <= COL_IDLE;
      db_cnt_reg    <= '0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      col_pat_reg   <= col_pat_next;
      db_cnt_reg    <= db_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_down_reg  <= key_down_next;
    end
  end

  // Everything happens on tick cycles only, i.e. after a full slot of settle
  // time on the currently driven row.
  always_comb begin
    state_next     = state_reg;
    row_idx_next   = row_idx_reg;
    col_idx_next   = col_idx_reg;
    col_pat_next   = col_pat_reg;
    db_cnt_next    = db_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_down_next  = key_down_reg;

    if (tick) begin
      case (state_reg)
        ST_SCAN: begin
          if (single_zero(col_sync_reg)) begin
            col_pat_next = col_sync_reg;
            col_idx_next = zero_index(col_sync_reg);
            db_cnt_next  = DBW'(1);
            state_next   = ST_PRESS_DB;
          end else begin
            row_idx_next = row_idx_reg + 2'd1;
          end
        end

        ST_PRESS_DB: begin
          if (col_sync_reg == col_pat_reg) begin
            if (db_done) begin
              state_next     = ST_HELD;
              key_code_next  = key_map(row_idx_reg, col_idx_reg);
              key_valid_next = 1'b1;
              key_down_next  = 1'b1;
            end else begin
              db_cnt_next = db_cnt_reg + DBW'(1);
            end
          end else begin
            state_next   = ST_SCAN;
            row_idx_next = row_idx_reg + 2'd1;
          end
        end

        // Only the latched column matters while held; other keys are ignored.
        ST_HELD: begin
          if (col_sync_reg[col_idx_reg]) begin
            state_next  = ST_REL_DB;
            db_cnt_next = DBW'(1);
          end
        end

        ST_REL_DB: begin
          if (col_sync_reg[col_idx_reg]) begin
            if (db_done) begin
              state_next    = ST_SCAN;
              key_down_next = 1'b0;
              row_idx_next  = row_idx_reg + 2'd1;
            end else begin
              db_cnt_next = db_cnt_reg + DBW'(1);
            end
          end else begin
            // Release bounce: back to held without a new strobe.
            state_next = ST_HELD;
          end
        end

        default: state_next = ST_SCAN;
      endcase
    end
  end

  // Digit entry: new digit enters at [3:0], the oldest falls off the top.
  assign bcd_shifted[3:0] = key_code_reg;

  genvar gi;
  generate
    for (gi = 1; gi < BCD_DIGITS; gi++) begin : g_shift
      assign bcd_shifted[4*gi +: 4] = bcd_reg[4*(gi-1) +: 4];
    end
  endgenerate

  // Updated on the strobe cycle from the already-registered code, so the new
  // entry is visible one clock after key_valid.
  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      bcd_reg <= '0;
    end else if (key_valid_reg) begin
      if (key_code_reg <= KEY_MAX_DIGIT) begin
        bcd_reg <= bcd_shifted;
      end else if (key_code_reg == KEY_STAR) begin
        bcd_reg <= '0;
      end
    end
  end

  assign row_out      = row_drive(row_idx_reg);
  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_down  = key_down_reg;
  assign kp.bcd_entry = bcd_reg;

endmodule

// File: tb/tb_keypad4x4_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad4x4_scanner
//   Directed bench for keypad4x4_scanner with a short slot (10 clks) and a
//   3-slot debounce. The keypad model pulls a column low whenever a pressed
//   key sits on the row currently driven low.
// ---------------------------------------------------------------------------
module tb_keypad4x4_scanner;

  localparam int SCAN_TICKS = 9;
  localparam int DB_SLOTS   = 3;
  localparam int BCD_DIGITS = 3;

  // Key indices are row*4 + col.
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K5 = 5;
  localparam int K7 = 8, K8 = 9, K9 = 10, KSTAR = 12;

  logic        clk_50MHz    = 1'b0;
  logic        reset_button = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] pressed = '0;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;
  int base;

  keypad4x4_scanner_if #(.BCD_DIGITS(BCD_DIGITS)) kp ();

  keypad4x4_scanner #(
    .SCAN_TICKS (SCAN_TICKS),
    .DB_SLOTS   (DB_SLOTS),
    .BCD_DIGITS (BCD_DIGITS)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .col_in       (col_in),
    .row_out      (row_out),
    .kp           (kp)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(posedge clk_50MHz) if (kp.key_valid === 1'b1) strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic wait_strobe(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50MHz);
      if (kp.key_valid === 1'b1) break;
    end
    check(tag, kp.key_valid, 1);
  endtask

  task automatic wait_release(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50MHz);
      if (kp.key_down === 1'b0) break;
    end
    check(tag, kp.key_down, 0);
  endtask

  // Press, wait for the accept, check code and the entry one clock later, release.
  task automatic press_key(input int idx, input logic [3:0] code, input logic [11:0] bcd_exp,
                           input string tag);
    pressed[idx] = 1'b1;
    wait_strobe({tag, "_strobe"});
    check({tag, "_code"}, kp.key_code, code);
    @(negedge clk_50MHz);
    check({tag, "_bcd"}, kp.bcd_entry, bcd_exp);
    pressed[idx] = 1'b0;
    wait_release({tag, "_release"});
  endtask

  initial begin
    // Reset values
    idle(3);
    check("rst_row", row_out, 4'b1110);
    check("rst_valid", kp.key_valid, 0);
    check("rst_down", kp.key_down, 0);
    check("rst_code", kp.key_code, 0);
    check("rst_bcd", kp.bcd_entry, 0);
    reset_button = 1'b0;

    // Row scan cadence with no key
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_50MHz);
      if (i == 9)  check("scan_row_c9", row_out, 4'b1110);
      if (i == 10) check("scan_row_c10", row_out, 4'b1101);
      if (i == 20) check("scan_row_c20", row_out, 4'b1011);
      if (i == 30) check("scan_row_c30", row_out, 4'b0111);
      if (i == 40) check("scan_row_c40", row_out, 4'b1110);
    end
    check("scan_no_strobe", strobes, 0);

    // '5' held 100 slots
    pressed[K5] = 1'b1;
    wait_strobe("k5_strobe");
    check("k5_code", kp.key_code, 4'h5);
    check("k5_down", kp.key_down, 1);
    check("k5_bcd_before", kp.bcd_entry, 12'h000);
    @(negedge clk_50MHz);
    check("k5_valid_one_cycle", kp.key_valid, 0);
    check("k5_bcd_after", kp.bcd_entry, 12'h005);
    idle(1000);
    check("k5_single_strobe", strobes, 1);
    check("k5_down_held", kp.key_down, 1);
    pressed[K5] = 1'b0;
    wait_release("k5_release");
    check("k5_no_strobe_on_release", strobes, 1);

    // Digit sequence 7, 3, 9
    press_key(K7, 4'h7, 12'h057, "k7");
    press_key(K3, 4'h3, 12'h573, "k3");
    press_key(K9, 4'h9, 12'h739, "k9");
    check("seq_strobes", strobes, 4);

    // Press bounce on '2': low for one slot only
    base = strobes;
    pressed[K2] = 1'b1;
    idle(10);
    pressed[K2] = 1'b0;
    idle(100);
    check("k2_bounce_no_strobe", strobes, base);

    // Release bounce while '2' is held
    pressed[K2] = 1'b1;
    wait_strobe("k2_strobe");
    check("k2_code", kp.key_code, 4'h2);
    @(negedge clk_50MHz);
    check("k2_bcd", kp.bcd_entry, 12'h392);
    idle(50);
    pressed[K2] = 1'b0;
    idle(10);
    pressed[K2] = 1'b1;
    idle(100);
    check("k2_relbounce_down", kp.key_down, 1);
    check("k2_relbounce_strobes", strobes, base + 1);
    pressed[K2] = 1'b0;
    wait_release("k2_release");

    // 'A' leaves the entry alone, '*' clears it
    press_key(KA, 4'hA, 12'h392, "kA");
    press_key(KSTAR, 4'hE, 12'h000, "kstar");

    // '1' and '2' together: two columns low, never accepted
    base = strobes;
    pressed[K1] = 1'b1;
    pressed[K2] = 1'b1;
    idle(300);
    check("k12_no_strobe", strobes, base);
    check("k12_no_down", kp.key_down, 0);
    pressed[K1] = 1'b0;
    pressed[K2] = 1'b0;
    idle(50);

    // Reset while '8' is held
    pressed[K8] = 1'b1;
    wait_strobe("k8_strobe");
    check("k8_code", kp.key_code, 4'h8);
    @(negedge clk_50MHz);
    check("k8_bcd", kp.bcd_entry, 12'h008);
    idle(20);
    reset_button = 1'b1;
    @(negedge clk_50MHz);
    check("k8_rst_row", row_out, 4'b1110);
    check("k8_rst_valid", kp.key_valid, 0);
    check("k8_rst_down", kp.key_down, 0);
    check("k8_rst_code", kp.key_code, 0);
    check("k8_rst_bcd", kp.bcd_entry, 0);
    reset_button = 1'b0;
    base = strobes;
    wait_strobe("k8_reaccept_strobe");
    check("k8_reaccept_code", kp.key_code, 4'h8);
    idle(300);
    check("k8_reaccept_once", strobes, base + 1);
    check("k8_reaccept_down", kp.key_down, 1);
    pressed[K8] = 1'b0;
    wait_release("k8_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
